// File: rtl/vxe_vpu_prod_eu_agen.sv
// Vector address generator: walks a 32-bit-element vector as 64-bit words with per-word element masks.
// Optional simulation checks are compiled in with `define VXE_VPU_AGEN_CHECKS_EN.
module vxe_vpu_prod_eu_agen (
    input  logic        clk,
    input  logic        nrst,
    input  logic [37:0] i_vaddr,
    input  logic [19:0] i_vlen,
    input  logic        i_latch,
    input  logic        i_incr,
    output logic        o_valid,
    output logic [36:0] o_addr,
    output logic [1:0]  o_we_mask
);

    logic [36:0] waddr;
    logic [19:0] rem;
    logic        odd;

    logic [1:0]  consume;
    logic [19:0] rem_dec;

    always_comb begin
        o_valid   = (rem != '0);
        o_addr    = waddr;
        o_we_mask = 2'b00;
        if (o_valid) begin
            if (odd)
                o_we_mask = 2'b10;
            else if (rem == 20'd1)
                o_we_mask = 2'b01;
            else
                o_we_mask = 2'b11;
        end
    end

    // Elements consumed by this word; saturate so rem can never wrap below zero.
    always_comb begin
        consume = {o_we_mask[1] & o_we_mask[0], o_we_mask[1] ^ o_we_mask[0]};
        rem_dec = '0;
        if (rem > {18'd0, consume})
            rem_dec = rem - {18'd0, consume};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            waddr <= '0;
            rem   <= '0;
            odd   <= 1'b0;
        end else if (i_latch) begin
            waddr <= i_vaddr[37:1];
            rem   <= i_vlen;
            odd   <= i_vaddr[0];
        end else if (i_incr && o_valid) begin
            waddr <= waddr + 37'd1;
            rem   <= rem_dec;
            odd   <= 1'b0;
        end
    end

`ifdef VXE_VPU_AGEN_CHECKS_EN
    always @(posedge clk) begin
        if (nrst) begin
            if (i_incr && !o_valid && !i_latch)
                $error("agen: i_incr asserted with no valid word");
            if (i_latch && ($isunknown(i_vaddr) || $isunknown(i_vlen)))
                $error("agen: unknown i_vaddr/i_vlen on latch");
        end
    end
`endif

endmodule

// File: tb/tb_vxe_vpu_prod_eu_agen.sv
// Self-checking bench for vxe_vpu_prod_eu_agen against an element-level reference model.
module tb_vxe_vpu_prod_eu_agen;

    logic        clk = 1'b0;
    logic        nrst;
    logic [37:0] i_vaddr;
    logic [19:0] i_vlen;
    logic        i_latch;
    logic        i_incr;
    logic        o_valid;
    logic [36:0] o_addr;
    logic [1:0]  o_we_mask;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Reference model: current element address and elements left.
    logic [37:0] m_elem;
    logic [19:0] m_left;

    always #5 clk = ~clk;

    vxe_vpu_prod_eu_agen dut (
        .clk       (clk),
        .nrst      (nrst),
        .i_vaddr   (i_vaddr),
        .i_vlen    (i_vlen),
        .i_latch   (i_latch),
        .i_incr    (i_incr),
        .o_valid   (o_valid),
        .o_addr    (o_addr),
        .o_we_mask (o_we_mask)
    );

    function automatic logic [1:0] exp_mask();
        if (m_left == 0)       return 2'b00;
        if (m_elem[0])         return 2'b10;
        if (m_left == 1)       return 2'b01;
        return 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(m_left != 0));
        chk({tag, ".addr"},  64'(o_addr),  64'(m_elem >> 1));
        chk({tag, ".mask"},  64'(o_we_mask), 64'(exp_mask()));
    endtask

    // One clock: drive at negedge, model the edge, check at the next negedge.
    task automatic cyc(input logic l, input logic [37:0] va, input logic [19:0] vl,
                       input logic inc, input string tag);
        logic [37:0] ne;
        logic [19:0] nl;
        int unsigned take;
        i_latch = l; i_vaddr = va; i_vlen = vl; i_incr = inc;
        ne = m_elem; nl = m_left;
        if (l) begin
            ne = va; nl = vl;
        end else if (inc && m_left != 0) begin
            take = (m_elem[0] || m_left == 1) ? 1 : 2;
            nl = m_left - 20'(take);
            ne = m_elem + 38'(take);
            if (take == 1) ne = m_elem + 38'd1;
            if (m_elem[0] == 1'b0 && take == 1) ne = m_elem + 38'd2;
        end
        @(posedge clk);
        m_elem = ne; m_left = nl;
        @(negedge clk);
        i_latch = 1'b0; i_incr = 1'b0;
        check_outputs(tag);
    endtask

    task automatic latch(input logic [37:0] va, input logic [19:0] vl, input string tag);
        cyc(1'b1, va, vl, 1'b0, tag);
    endtask

    task automatic incr(input string tag);
        cyc(1'b0, '0, '0, 1'b1, tag);
    endtask

    initial begin
        logic [63:0] r;
        nrst = 1'b0; i_vaddr = '0; i_vlen = '0; i_latch = 1'b0; i_incr = 1'b0;
        m_elem = '0; m_left = '0;
        #12;
        chk("reset.valid", 64'(o_valid), 64'd0);
        chk("reset.addr",  64'(o_addr), 64'd0);
        chk("reset.mask",  64'(o_we_mask), 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Aligned one-element vector
        latch(38'h100, 20'd1, "a1.load");
        chk("a1.addr_const", 64'(o_addr), 64'h80);
        chk("a1.mask_const", 64'(o_we_mask), 64'h1);
        incr("a1.done");
        chk("a1.valid_const", 64'(o_valid), 64'd0);

        // Unaligned one-element vector
        latch(38'h101, 20'd1, "u1.load");
        chk("u1.mask_const", 64'(o_we_mask), 64'h2);
        incr("u1.done");

        // Suspend/resume
        latch(38'h100, 20'd8, "sr.load");
        incr("sr.i1");
        cyc(1'b0, '0, '0, 1'b0, "sr.idle");
        chk("sr.hold_const", 64'(o_addr), 64'h81);
        for (int unsigned k = 0; k < 3; k++) incr("sr.in");
        chk("sr.end_const", 64'(o_valid), 64'd0);

        // Unaligned base
        latch(38'h101, 20'd7, "ub.load");
        for (int unsigned k = 0; k < 4; k++) incr("ub.in");

        // Unaligned length, then latch+incr reload mid-vector
        latch(38'h100, 20'd9, "ul.load");
        for (int unsigned k = 0; k < 4; k++) incr("ul.in");
        chk("ul.last_const", 64'(o_we_mask), 64'h1);
        incr("ul.end");
        latch(38'h100, 20'd9, "ul.reload");
        incr("ul.i1");
        cyc(1'b1, 38'h200, 20'd3, 1'b1, "ul.latch_incr");
        chk("ul.reload_const", 64'(o_addr), 64'h100);

        // Both unaligned, extra incr, async reset mid-vector
        latch(38'h101, 20'd8, "bu.load");
        for (int unsigned k = 0; k < 5; k++) incr("bu.in");
        incr("bu.extra");
        latch(38'h101, 20'd8, "bu.reload");
        incr("bu.i1");
        #3 nrst = 1'b0;
        #1;
        m_elem = '0; m_left = '0;
        check_outputs("bu.async_rst");
        @(negedge clk);
        nrst = 1'b1;

        // Zero length and word-address wrap
        latch(38'h55, 20'd0, "z.load");
        incr("z.incr");
        latch(38'h3F_FFFF_FFFD, 20'd5, "w.load");
        for (int unsigned k = 0; k < 4; k++) incr("w.in");

        // Random traffic
        for (int unsigned k = 0; k < 400; k++) begin
            r = {$urandom, $urandom};
            cyc(($urandom_range(0, 7) == 0), r[37:0], 20'($urandom_range(0, 12)),
                1'($urandom_range(0, 3) != 0), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
